// File: rtl/ai_irq_pkg.sv
// Shared constants for the AI comparer interrupt aggregator.
package ai_irq_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_MASK   = 4'd1;
    localparam logic [3:0] ADDR_MODE   = 4'd2;
    localparam logic [3:0] ADDR_COUNT  = 4'd3;
    localparam logic [3:0] ADDR_PCLR   = 4'd4;
    localparam logic [3:0] ADDR_ACK    = 4'd5;
    localparam logic [3:0] ADDR_FLAGS  = 4'd6;

    typedef enum logic {
        MODE_ALL = 1'b0,
        MODE_ANY = 1'b1
    } mode_e;

endpackage

// File: rtl/ai_irq_if.sv
// Avalon-MM slave bus plus interrupt line of the aggregator.
interface ai_irq_if #(
    parameter int DATA_W = 32
);
    logic              avs_s0_write;
    logic              avs_s0_read;
    logic [3:0]        avs_s0_address;
    logic [DATA_W-1:0] avs_s0_writedata;
    logic [DATA_W-1:0] avs_s0_readdata;
    logic              avm_s0_irq;

    modport master (
        output avs_s0_write, avs_s0_read,
        output avs_s0_address, avs_s0_writedata,
        input  avs_s0_readdata, avm_s0_irq
    );

    modport slave (
        input  avs_s0_write, avs_s0_read,
        input  avs_s0_address, avs_s0_writedata,
        output avs_s0_readdata, avm_s0_irq
    );
endinterface

// File: rtl/ai_irq_aggregator_pending_bank.sv
// Sticky per-channel pending bits and the ALL/ANY fire reduction.
module ai_irq_pending_bank
    import ai_irq_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_set,
    input  logic [NUM_CH-1:0] i_mask,
    input  mode_e             i_mode,
    input  logic              i_clr_we,
    input  logic [NUM_CH-1:0] i_clr_bits,
    output logic [NUM_CH-1:0] o_pending,
    output logic              o_fire
);

    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] w_next;
    logic              w_all;
    logic              w_any;

    always_comb begin
        w_all  = (i_mask != '0) && (&(r_pend | ~i_mask));
        w_any  = |(r_pend & i_mask);
        o_fire = (i_mode == MODE_ANY) ? w_any : w_all;
    end

    // Sets are applied last so a same-cycle pulse always survives.
    always_comb begin
        w_next = r_pend;
        if (o_fire)
            w_next = w_next & ~i_mask;
        if (i_clr_we)
            w_next = w_next & ~i_clr_bits;
        w_next = w_next | i_set;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_pend <= '0;
        else
            r_pend <= w_next;
    end

    assign o_pending = r_pend;

endmodule

// File: rtl/ai_irq_aggregator.sv
// Interrupt aggregator: register file, event counter and readback.
module ai_irq_aggregator
    import ai_irq_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] irq_in,
    ai_irq_if.slave           s0
);

    logic [NUM_CH-1:0] r_mask;
    mode_e             r_mode;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovr;
    logic              r_irq;
    logic [DATA_W-1:0] r_rdata;

    logic [NUM_CH-1:0] w_pending;
    logic              w_fire;
    logic [DATA_W-1:0] w_rdata;
    logic              w_wr_mask;
    logic              w_wr_mode;
    logic              w_wr_pclr;
    logic              w_wr_ack;
    logic              w_wr_flags;
    logic              w_unused;

    assign w_unused = &{1'b0, s0.avs_s0_writedata};

    always_comb begin
        w_wr_mask  = 1'b0;
        w_wr_mode  = 1'b0;
        w_wr_pclr  = 1'b0;
        w_wr_ack   = 1'b0;
        w_wr_flags = 1'b0;
        if (s0.avs_s0_write) begin
            case (s0.avs_s0_address)
                ADDR_MASK:  w_wr_mask  = 1'b1;
                ADDR_MODE:  w_wr_mode  = 1'b1;
                ADDR_PCLR:  w_wr_pclr  = 1'b1;
                ADDR_ACK:   w_wr_ack   = 1'b1;
                ADDR_FLAGS: w_wr_flags = 1'b1;
                default:    ;
            endcase
        end
    end

    ai_irq_pending_bank #(
        .NUM_CH (NUM_CH)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .i_set      (irq_in),
        .i_mask     (r_mask),
        .i_mode     (r_mode),
        .i_clr_we   (w_wr_pclr),
        .i_clr_bits (s0.avs_s0_writedata[NUM_CH-1:0]),
        .o_pending  (w_pending),
        .o_fire     (w_fire)
    );

    always_comb begin
        w_rdata = '0;
        case (s0.avs_s0_address)
            ADDR_STATUS: w_rdata[NUM_CH-1:0] = w_pending;
            ADDR_MASK:   w_rdata[NUM_CH-1:0] = r_mask;
            ADDR_MODE:   w_rdata[0]          = r_mode;
            ADDR_COUNT:  w_rdata[CNT_W-1:0]  = r_cnt;
            ADDR_FLAGS:  w_rdata[1:0]        = {r_irq, r_ovr};
            default:     ;
        endcase
    end

    // A fire on the same edge as an ACK or overrun clear takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask  <= '1;
            r_mode  <= MODE_ALL;
            r_cnt   <= '0;
            r_ovr   <= 1'b0;
            r_irq   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_wr_mask)
                r_mask <= s0.avs_s0_writedata[NUM_CH-1:0];
            if (w_wr_mode)
                r_mode <= mode_e'(s0.avs_s0_writedata[0]);
            if (w_fire)
                r_cnt <= r_cnt + 1'b1;
            if (w_fire)
                r_irq <= 1'b1;
            else if (w_wr_ack)
                r_irq <= 1'b0;
            if (w_fire && r_irq)
                r_ovr <= 1'b1;
            else if (w_wr_flags && s0.avs_s0_writedata[0])
                r_ovr <= 1'b0;
            if (s0.avs_s0_read)
                r_rdata <= w_rdata;
        end
    end

    assign s0.avs_s0_readdata = r_rdata;
    assign s0.avm_s0_irq      = r_irq;

endmodule

// File: tb/tb_ai_irq_aggregator.sv
// Table-driven bench for ai_irq_aggregator with a read-data scoreboard.
module tb_ai_irq_aggregator;
    import ai_irq_pkg::*;

    typedef struct {
        logic        rst;
        logic [3:0]  irq;
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        e_irq;
        logic [31:0] e_rd;
    } step_t;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] sb[$];
    step_t       tbl[$];

    ai_irq_if #(.DATA_W(32)) bus ();

    ai_irq_aggregator #(
        .NUM_CH (4),
        .DATA_W (32),
        .CNT_W  (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .s0     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic step_t mk(
        logic r, logic [3:0] i, logic w, logic rd,
        logic [3:0] a, logic [31:0] d,
        logic ei, logic [31:0] er);
        step_t s;
        s.rst = r; s.irq = i; s.wr = w; s.rd = rd;
        s.addr = a; s.data = d;
        s.e_irq = ei; s.e_rd = er;
        return s;
    endfunction

    task automatic check(input string nm,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic apply(input step_t s, input string nm);
        logic [31:0] exp;
        @(negedge clk);
        rst                  = s.rst;
        irq_in               = s.irq;
        bus.avs_s0_write     = s.wr;
        bus.avs_s0_read      = s.rd;
        bus.avs_s0_address   = s.addr;
        bus.avs_s0_writedata = s.data;
        if (s.rd)
            sb.push_back(s.e_rd);
        @(posedge clk);
        #1;
        check({nm, " irq"}, 32'(bus.avm_s0_irq), 32'(s.e_irq));
        if (s.rd) begin
            exp = sb.pop_front();
            check({nm, " rdata"}, bus.avs_s0_readdata, exp);
        end
    endtask

    initial begin
        rst                  = 1'b1;
        irq_in               = '0;
        bus.avs_s0_write     = 1'b0;
        bus.avs_s0_read      = 1'b0;
        bus.avs_s0_address   = '0;
        bus.avs_s0_writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset irq", 32'(bus.avm_s0_irq), 32'd0);
        check("reset rdata", bus.avs_s0_readdata, 32'd0);

        // ALL mode, default mask
        tbl.push_back(mk(0, 4'h1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h8, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_STATUS, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_COUNT, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_FLAGS, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 0, ADDR_ACK, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_FLAGS, 0, 0, 0));
        // Partial mask in ALL mode
        tbl.push_back(mk(0, 0, 1, 0, ADDR_MASK, 3, 0, 0));
        tbl.push_back(mk(0, 4'h4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h3, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_STATUS, 0, 1, 4));
        tbl.push_back(mk(0, 0, 1, 0, ADDR_ACK, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_FLAGS, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, ADDR_PCLR, 4, 0, 0));
        // ANY mode, overrun, count wrap
        tbl.push_back(mk(0, 0, 1, 0, ADDR_MODE, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, ADDR_MASK, 4, 0, 0));
        tbl.push_back(mk(0, 4'h1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_COUNT, 0, 1, 3));
        tbl.push_back(mk(0, 4'h4, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_FLAGS, 0, 1, 3));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_COUNT, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, ADDR_FLAGS, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_FLAGS, 0, 1, 2));
        // Same-cycle fire/ACK, pulse vs clear
        tbl.push_back(mk(0, 0, 1, 0, ADDR_PCLR, 4'hf, 1, 0));
        tbl.push_back(mk(0, 4'h4, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'h1, 1, 0, ADDR_ACK, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_STATUS, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_FLAGS, 0, 1, 3));
        tbl.push_back(mk(0, 4'h1, 1, 0, ADDR_PCLR, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_STATUS, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_COUNT, 0, 1, 1));
        // Reset mid-operation
        tbl.push_back(mk(0, 0, 1, 0, ADDR_MASK, 0, 1, 0));
        tbl.push_back(mk(0, 4'h4, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_STATUS, 0, 1, 5));
        tbl.push_back(mk(1, 4'hf, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_STATUS, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_MASK, 0, 0, 4'hf));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_COUNT, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_FLAGS, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, ADDR_MODE, 0, 0, 0));

        foreach (tbl[i])
            apply(tbl[i], $sformatf("row%0d", i));

        // MASK write edge must not fire; next edge does
        apply(mk(0, 4'h3, 0, 0, 0, 0, 0, 0), "mw_set");
        apply(mk(0, 0, 1, 0, ADDR_MASK, 3, 0, 0), "mw_edge");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0), "mw_fire");
        // Readback hold and unmapped accesses
        apply(mk(0, 0, 0, 1, ADDR_MASK, 0, 1, 3), "rd_mask");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0), "rd_idle");
        check("rd_hold", bus.avs_s0_readdata, 32'd3);
        apply(mk(0, 0, 1, 0, 4'd7, 32'hffff, 1, 0), "wr_unmap");
        apply(mk(0, 0, 0, 1, ADDR_MASK, 0, 1, 3), "rd_mask2");
        apply(mk(0, 0, 0, 1, 4'd7, 0, 1, 0), "rd_unmap");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0), "done");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
